circulant_parity_accumulator: RTL and testbench
===============================================

Name: circulant_parity_accumulator

Overview:
- Encoder stage directly downstream of Function_generator0.
- Drives the generator's 2-bit row address and consumes the returned 256-bit base row.
- For each base row it generates LM circulant shifts and computes one parity bit per shift: parity = XOR-reduce(msg AND rotated row).
- Serialises the 4 x LM = 64 parity bits over 64 cycles and presents them as one registered word with a valid/ready handshake.

Parameters:
K_N, 256, message width and generator row width
LM, 16, circulant shifts per base row
N_ROWS, 4, number of base rows; fixes adrs width at 2
N_P, 64, parity word width (N_ROWS*LM)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset; also tied to the generator's rst
msg_in  in  K_N  message block
msg_valid  in  1  message present
msg_ready  out  1  block can accept a message
adrs  out  2  row address to Function_generator0
f_in  in  K_N  base row returned combinationally by the generator for the current adrs
parity_out  out  N_P  parity word, registered
parity_valid  out  1  parity_out holds a complete result
parity_ready  in  1  downstream consumes the result

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, msg_ready=1, adrs=0, parity_out=0, parity_valid=0, cnt=0, msg_reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - msg_ready=1.
  - On msg_valid&&msg_ready: latch msg_in into msg_reg, clear the parity accumulator and cnt, go to RUN.
  - msg_ready deasserts the cycle after acceptance.
- RUN:
  - cnt is a 6-bit register, 0..N_P-1.
  - adrs = cnt[5:4] (registered output, stable for 16 cycles).
  - j = cnt[3:0].
  - Each cycle: r[i] = f_in[(i-j) mod K_N] (rotate left by j); bit p = ^(msg_reg & r); stored at parity index cnt = adrs*LM + j.
  - f_in is sampled in the same cycle adrs is presented. The generator is combinational, so there is no wait state.
  - After cnt = 63: go to DONE and load parity_out.
- DONE:
  - parity_valid=1; parity_out is stable.
  - On parity_ready: parity_valid drops and the FSM returns to IDLE; msg_ready=1 the next cycle.
  - parity_ready while not in DONE is ignored.
- Latency:
  - Message accepted at edge 0; RUN occupies edges 1..64; parity_valid is high from after edge 64.
  - Minimum 66 cycles message-to-message with parity_ready held high.
- No overlap: msg_valid during RUN or DONE is ignored (msg_ready=0), and the message must be held by the source.
- Wrap-around: cnt does not wrap inside RUN. The 63->0 transition happens only on a new acceptance.
- Simultaneous events:
  - In DONE, parity_ready and msg_valid in the same cycle: only parity_ready takes effect.
  - The message is accepted in IDLE on the following cycle.
- Reset mid-operation: any state returns to IDLE immediately. The partial parity is discarded and parity_valid drops asynchronously.
- adrs holds 0 in IDLE and DONE.

Decomposition:
- Shared package:
  - K_N, LM, N_ROWS, N_P.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter width localparam CNT_W=6.
- Sub-module circulant_row_parity (combinational):
  - Inputs: msg[K_N-1:0], row[K_N-1:0], shift[3:0].
  - Output: 1-bit parity.
  - Contains the rotate and XOR-reduce. It is reused by the bench's reference model.
- Top module: FSM, counter, msg_reg, parity shift/accumulate register, handshake.

Test Plan:
- Reset, then msg_in=0, msg_valid pulse -> after 65 cycles parity_valid=1 and parity_out=64'h0; adrs sequence is 0 (x16), 1 (x16), 2 (x16), 3 (x16).
- msg_in=256'h1 (bit0 only), generator rows as coded:
  - parity[0]=f0[0]=1.
  - parity[j]=f0[256-j] for j=1..15, so parity[1]=1, parity[2]=0, parity[3]=0, parity[4]=0, parity[5]=1.
  - Remaining bits match the reference model.
- msg_in all ones -> each 16-bit group a equals XOR-reduce of row a replicated 16 times (rotation invariant); compare to model.
- Backpressure:
  - Hold parity_ready=0 for 10 cycles in DONE -> parity_out stable, msg_ready=0.
  - A second msg_valid is ignored.
  - Release parity_ready -> IDLE, msg_ready=1 next cycle.
- Assert rst at cnt=30 -> adrs=0, parity_valid=0, msg_ready=1 immediately. A new message then completes with correct parity, with no residue from the aborted run.
- Back-to-back: 100 random messages with parity_ready tied high -> every result matches the model, and accept-to-accept spacing is 66 cycles.

Source files
------------

// File: rtl/circulant_parity_accumulator_pkg.sv
// Shared sizes and state encoding for the circulant parity accumulator.
package circulant_parity_accumulator_pkg;

    localparam int unsigned K_N     = 256;  // message / generator row width
    localparam int unsigned LM      = 16;   // circulant shifts per base row
    localparam int unsigned N_ROWS  = 4;    // base rows served by the generator
    localparam int unsigned N_P     = 64;   // parity word width (N_ROWS*LM)
    localparam int unsigned CNT_W   = 6;    // parity bit counter width
    localparam int unsigned ADRS_W  = 2;    // generator row address width
    localparam int unsigned SHIFT_W = 4;    // circulant shift width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/circulant_row_parity.sv
// Parity of a message against one circulant shift of a generator base row.
module circulant_row_parity
    import circulant_parity_accumulator_pkg::*;
(
    input  logic [K_N-1:0]     msg,
    input  logic [K_N-1:0]     row,
    input  logic [SHIFT_W-1:0] shift,
    output logic               parity
);

    logic [2*K_N-1:0] row_dbl;
    logic [8:0]       base;
    logic [K_N-1:0]   rot;

    // Rotate left by shift: rot[i] = row[(i - shift) mod K_N], taken from a doubled copy
    assign row_dbl = {row, row};
    assign base    = 9'(K_N) - 9'(shift);
    assign rot     = row_dbl[base +: K_N];

    // XOR-reduce of the masked rotated row
    assign parity  = ^(msg & rot);

endmodule

// File: rtl/circulant_parity_accumulator.sv
// Walks the generator's base rows, computes one parity bit per circulant shift
// and hands the 64-bit parity word downstream with a valid/ready handshake.
module circulant_parity_accumulator
    import circulant_parity_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [K_N-1:0]    msg_in,
    input  logic              msg_valid,
    output logic              msg_ready,
    output logic [ADRS_W-1:0] adrs,
    input  logic [K_N-1:0]    f_in,
    output logic [N_P-1:0]    parity_out,
    output logic              parity_valid,
    input  logic              parity_ready
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [K_N-1:0]    msg_reg, msg_d;
    logic [N_P-1:0]    acc_q, acc_d;
    logic [ADRS_W-1:0] adrs_d;
    logic              msg_ready_d;
    logic              parity_valid_d;
    logic [N_P-1:0]    parity_out_d;
    logic              row_par;

    // Parity of the latched message against the current shift of the presented row
    circulant_row_parity u_row_parity (
        .msg    (msg_reg),
        .row    (f_in),
        .shift  (cnt_q[SHIFT_W-1:0]),
        .parity (row_par)
    );

    // State, counter, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            msg_reg      <= '0;
            acc_q        <= '0;
            adrs         <= '0;
            msg_ready    <= 1'b1;
            parity_valid <= 1'b0;
            parity_out   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            msg_reg      <= msg_d;
            acc_q        <= acc_d;
            adrs         <= adrs_d;
            msg_ready    <= msg_ready_d;
            parity_valid <= parity_valid_d;
            parity_out   <= parity_out_d;
        end
    end

    // Next-state and next-output logic; the accumulator shifts in from the MSB so
    // the bit computed at count c lands at index c after the 64th shift
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        msg_d          = msg_reg;
        acc_d          = acc_q;
        adrs_d         = '0;
        msg_ready_d    = msg_ready;
        parity_valid_d = parity_valid;
        parity_out_d   = parity_out;

        case (state_q)
            IDLE: begin
                msg_ready_d = 1'b1;
                if (msg_valid && msg_ready) begin
                    msg_d       = msg_in;
                    acc_d       = '0;
                    cnt_d       = '0;
                    msg_ready_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                acc_d = {row_par, acc_q[N_P-1:1]};
                if (cnt_q == CNT_W'(N_P - 1)) begin
                    parity_out_d   = acc_d;
                    parity_valid_d = 1'b1;
                    state_d        = DONE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    adrs_d = cnt_d[CNT_W-1 -: ADRS_W];
                end
            end
            DONE: begin
                parity_valid_d = 1'b1;
                if (parity_ready) begin
                    parity_valid_d = 1'b0;
                    msg_ready_d    = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_circulant_parity_accumulator.sv
// Bench for circulant_parity_accumulator: behavioural generator, independent
// parity model, scoreboard on the parity handshake, directed corner sequences.
module tb_circulant_parity_accumulator;
    import circulant_parity_accumulator_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [K_N-1:0]    msg_in;
    logic              msg_valid;
    logic              msg_ready;
    logic [ADRS_W-1:0] adrs;
    logic [K_N-1:0]    f_in;
    logic [N_P-1:0]    parity_out;
    logic              parity_valid;
    logic              parity_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [N_P-1:0] sb[$];

    typedef struct {
        logic [K_N-1:0] msg;
        logic [N_P-1:0] mask;
        logic [N_P-1:0] val;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    circulant_parity_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .msg_in       (msg_in),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .adrs         (adrs),
        .f_in         (f_in),
        .parity_out   (parity_out),
        .parity_valid (parity_valid),
        .parity_ready (parity_ready)
    );

    // Stand-in for Function_generator0: combinational base rows by address
    function automatic logic [K_N-1:0] gen_row(input logic [1:0] a);
        case (a)
            2'd0:    return {64'h8812_3456_789A_BCDE, 64'h0F1E_2D3C_4B5A_6978,
                             64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_0246_8AC1};
            2'd1:    return {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                             64'hA5A5_5A5A_C3C3_3C3C, 64'h0000_FFFF_1111_EEEE};
            2'd2:    return {64'h7777_0000_8888_1234, 64'h1F2E_3D4C_5B6A_7988,
                             64'h0102_0408_1020_4080, 64'hFFFF_0000_0000_0001};
            default: return {64'h6B8B_4567_327B_23C6, 64'h6433_4873_74B0_DC51,
                             64'h19E4_58EC_2AE8_944A, 64'h625D_A19A_2389_4C3E};
        endcase
    endfunction

    assign f_in = gen_row(adrs);

    // Reference: bit a*16+j = XOR over i of msg[i] & row_a[(i - j) mod 256]
    function automatic logic [N_P-1:0] model(input logic [K_N-1:0] m);
        logic [N_P-1:0] res;
        logic [K_N-1:0] rw;
        logic [K_N-1:0] r;
        res = '0;
        for (int a = 0; a < 4; a++) begin
            rw = gen_row(2'(a));
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 256; i++) r[i] = rw[(i + 256 - j) % 256];
                res[a*16 + j] = ^(m & r);
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a message until accepted; pushes the model result and returns the acceptance cycle
    task automatic send_msg(input logic [K_N-1:0] m, output int acc_cyc);
        msg_in    = m;
        msg_valid = 1'b1;
        acc_cyc   = -1;
        for (int n = 0; n < 300; n++) begin
            if (msg_ready) begin
                acc_cyc = cyc;
                sb.push_back(model(m));
                step();
                msg_valid = 1'b0;
                return;
            end
            step();
        end
        msg_valid = 1'b0;
        timeout("accept");
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 200; n++) begin
            if (parity_valid) return;
            step();
        end
        timeout("parity_valid");
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0 && msg_ready && !parity_valid) return;
            step();
        end
        timeout("drain");
    endtask

    initial begin
        int t;
        int prev;
        logic [N_P-1:0] exp_a;
        logic [K_N-1:0] m;

        rst          = 1'b1;
        msg_in       = '0;
        msg_valid    = 1'b0;
        parity_ready = 1'b1;

        // Scoreboard: compare every result as it is handed over
        fork
            forever begin
                @(negedge clk);
                if (!rst && parity_valid && parity_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL scoreboard: unexpected result %h", parity_out);
                    end else begin
                        chk("scoreboard", parity_out, sb.pop_front());
                    end
                end
            end
        join_none

        vecs[0] = '{msg: '0, mask: '1, val: '0};
        vecs[1] = '{msg: 256'h1, mask: 64'h3F, val: 64'h23};
        vecs[2] = '{msg: '1, mask: '1,
                    val: {{16{^gen_row(2'd3)}}, {16{^gen_row(2'd2)}},
                          {16{^gen_row(2'd1)}}, {16{^gen_row(2'd0)}}}};
        vecs[3] = '{msg: 256'h20, mask: 64'hFF, val: 64'h60};

        repeat (3) step();
        chk("rst_msg_ready", 64'(msg_ready), 64'd1);
        chk("rst_adrs", 64'(adrs), 64'd0);
        chk("rst_parity_valid", 64'(parity_valid), 64'd0);
        chk("rst_parity_out", parity_out, 64'd0);
        rst = 1'b0;
        step();

        // Zero message: adrs sequence and acceptance-to-valid latency
        send_msg('0, t);
        for (int i = 0; i < 64; i++) begin
            chk("adrs_seq", 64'(adrs), 64'(i / 16));
            chk("run_msg_ready", 64'(msg_ready), 64'd0);
            step();
        end
        chk("latency_valid", 64'(parity_valid), 64'd1);
        chk("zero_parity", parity_out, 64'd0);
        wait_drain();

        // Table of hand-derived expectations
        for (int v = 0; v < 4; v++) begin
            send_msg(vecs[v].msg, t);
            wait_valid();
            chk($sformatf("vec%0d", v), parity_out & vecs[v].mask, vecs[v].val);
            wait_drain();
        end

        // Backpressure in DONE; a message offered meanwhile must wait
        parity_ready = 1'b0;
        m = {8{32'h1234_5678}};
        exp_a = model(m);
        send_msg(m, t);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_parity_out", parity_out, exp_a);
            chk("hold_valid", 64'(parity_valid), 64'd1);
            chk("hold_msg_ready", 64'(msg_ready), 64'd0);
            if (i == 0) begin
                msg_in    = {8{32'hCAFE_0001}};
                msg_valid = 1'b1;
            end
            step();
        end
        parity_ready = 1'b1;
        step();
        chk("release_valid", 64'(parity_valid), 64'd0);
        chk("release_msg_ready", 64'(msg_ready), 64'd1);
        send_msg({8{32'hCAFE_0001}}, t);
        wait_drain();

        // Reset at cnt = 30 discards the run
        send_msg({8{32'hDEAD_0BAD}}, t);
        repeat (30) step();
        chk("pre_rst_adrs", 64'(adrs), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_adrs", 64'(adrs), 64'd0);
        chk("abort_valid", 64'(parity_valid), 64'd0);
        chk("abort_msg_ready", 64'(msg_ready), 64'd1);
        void'(sb.pop_back());
        step();
        rst = 1'b0;
        step();
        send_msg({8{32'h0F0F_7E57}}, t);
        wait_drain();

        // Back-to-back random messages, ready held high
        prev = 0;
        for (int k = 0; k < 100; k++) begin
            for (int w = 0; w < 8; w++) m[w*32 +: 32] = $urandom;
            send_msg(m, t);
            if (k > 0) chk("spacing", 64'(t - prev), 64'd66);
            prev = t;
        end
        wait_drain();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
